// File: rtl/sram_fifo_ctrl.sv
// FIFO controller for a 16x8 two-port SRAM: port 1 writes, port 2 reads, valid/ready on both sides.
// Define SRAM_FIFO_LEVEL_EN to expose the occupancy count on the optional `level` output.
module sram_fifo_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] sram_a1,
    output logic [DW-1:0] sram_i1,
    output logic          sram_csb1,
    output logic          sram_web1,
    output logic          sram_oeb1,
    output logic [AW-1:0] sram_a2,
    output logic          sram_csb2,
    output logic          sram_oeb2,
    output logic          sram_web2,
`ifdef SRAM_FIFO_LEVEL_EN
    output logic [AW:0]   level,
`endif
    input  logic [DW-1:0] sram_o2
);

    typedef enum logic [1:0] {
        R_IDLE,
        R_CMD,
        R_HOLD
    } rdState_t;

    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    rdState_t      r_state;
    rdState_t      w_stateNext;

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] w_rptrNext;
    logic [AW:0]   r_occ;
    logic [AW:0]   w_occNext;
    logic [AW:0]   r_committed;
    logic [AW:0]   w_committedNext;

    logic          r_csb1;
    logic          r_web1;
    logic [AW-1:0] r_a1;
    logic [DW-1:0] r_i1;
    logic          r_csb2;
    logic          r_oeb2;
    logic [AW-1:0] r_a2;
    logic          w_csb2Next;
    logic          w_oeb2Next;
    logic [AW-1:0] w_a2Next;

    logic          w_wrFire;
    logic          w_rdFire;
    logic          w_commit;

    assign wr_ready  = (r_occ < L_DEPTH);
    assign rd_valid  = (r_state == R_HOLD);
    assign rd_data   = sram_o2;

    assign w_wrFire  = wr_valid & wr_ready;
    assign w_rdFire  = rd_valid & rd_ready;
    // The write command registered last edge is the one the SRAM performs on this edge.
    assign w_commit  = ~r_csb1 & ~r_web1;

    assign sram_a1   = r_a1;
    assign sram_i1   = r_i1;
    assign sram_csb1 = r_csb1;
    assign sram_web1 = r_web1;
    assign sram_oeb1 = 1'b1;
    assign sram_a2   = r_a2;
    assign sram_csb2 = r_csb2;
    assign sram_oeb2 = r_oeb2;
    assign sram_web2 = 1'b1;

`ifdef SRAM_FIFO_LEVEL_EN
    assign level = r_occ;
`endif

    always_comb begin
        w_occNext = r_occ;
        if (w_wrFire && !w_rdFire) begin
            w_occNext = r_occ + 1'b1;
        end else if (!w_wrFire && w_rdFire) begin
            w_occNext = r_occ - 1'b1;
        end
    end

    always_comb begin
        w_committedNext = r_committed;
        if (w_commit && !w_rdFire) begin
            w_committedNext = r_committed + 1'b1;
        end else if (!w_commit && w_rdFire) begin
            w_committedNext = r_committed - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_occ       <= '0;
            r_committed <= '0;
            r_csb1      <= 1'b1;
            r_web1      <= 1'b1;
            r_a1        <= '0;
            r_i1        <= '0;
        end else begin
            r_csb1      <= ~w_wrFire;
            r_web1      <= ~w_wrFire;
            r_occ       <= w_occNext;
            r_committed <= w_committedNext;
            if (w_wrFire) begin
                r_a1   <= r_wptr;
                r_i1   <= wr_data;
                r_wptr <= r_wptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= R_IDLE;
            r_rptr  <= '0;
            r_csb2  <= 1'b1;
            r_oeb2  <= 1'b1;
            r_a2    <= '0;
        end else begin
            r_state <= w_stateNext;
            r_rptr  <= w_rptrNext;
            r_csb2  <= w_csb2Next;
            r_oeb2  <= w_oeb2Next;
            r_a2    <= w_a2Next;
        end
    end

    // A pop can chain straight into the next read when a word is still committed after it.
    always_comb begin
        w_stateNext = r_state;
        w_rptrNext  = r_rptr;
        w_csb2Next  = 1'b1;
        w_oeb2Next  = 1'b1;
        w_a2Next    = r_a2;
        case (r_state)
            R_IDLE: begin
                if (r_committed != '0) begin
                    w_csb2Next  = 1'b0;
                    w_oeb2Next  = 1'b0;
                    w_a2Next    = r_rptr;
                    w_stateNext = R_CMD;
                end
            end
            R_CMD: begin
                w_stateNext = R_HOLD;
            end
            R_HOLD: begin
                if (rd_ready) begin
                    w_rptrNext = r_rptr + 1'b1;
                    if (w_committedNext != '0) begin
                        w_csb2Next  = 1'b0;
                        w_oeb2Next  = 1'b0;
                        w_a2Next    = r_rptr + 1'b1;
                        w_stateNext = R_CMD;
                    end else begin
                        w_stateNext = R_IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = R_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl with a behavioural two-port SRAM and a queue-based FIFO model.
// Also builds with SRAM_FIFO_LEVEL_EN defined, in which case `level` is checked against the model.
module tb_sram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] sram_a1;
    logic [DW-1:0] sram_i1;
    logic          sram_csb1;
    logic          sram_web1;
    logic          sram_oeb1;
    logic [AW-1:0] sram_a2;
    logic          sram_csb2;
    logic          sram_oeb2;
    logic          sram_web2;
    logic [DW-1:0] sram_o2;
`ifdef SRAM_FIFO_LEVEL_EN
    logic [AW:0]   level;
`endif

    int            checks = 0;
    int            failures = 0;
    int            pops = 0;
    logic [DW-1:0] model[$];
    logic [DW-1:0] lastPop;
    logic [AW-1:0] expWrAddr;
    logic [AW-1:0] expRdAddr;
    logic [AW-1:0] prevA1;
    logic [AW-1:0] prevA2;
    bit            prevA1Valid;
    bit            prevA2Valid;
    bit            sawWrWrap;
    bit            sawRdWrap;
    logic [DW-1:0] memory [DEPTH];

    sram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .sram_a1   (sram_a1),
        .sram_i1   (sram_i1),
        .sram_csb1 (sram_csb1),
        .sram_web1 (sram_web1),
        .sram_oeb1 (sram_oeb1),
        .sram_a2   (sram_a2),
        .sram_csb2 (sram_csb2),
        .sram_oeb2 (sram_oeb2),
        .sram_web2 (sram_web2),
`ifdef SRAM_FIFO_LEVEL_EN
        .level     (level),
`endif
        .sram_o2   (sram_o2)
    );

    always #5 clk = ~clk;

    // SRAM macro: both ports act on the clock edge using the pins as registered before it.
    always @(posedge clk) begin
        if (sram_csb1 === 1'b0 && sram_web1 === 1'b0) begin
            memory[sram_a1] <= sram_i1;
        end
        if (sram_csb2 === 1'b0 && sram_oeb2 === 1'b0) begin
            sram_o2 <= memory[sram_a2];
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: score the handshakes the DUT sees at this edge, advance, then check registered outputs.
    task automatic applyStimulus();
        bit            inReset;
        bit            wrFire;
        bit            rdFire;
        logic [DW-1:0] wData;
        logic [DW-1:0] expData;
        inReset = !reset_n;
        wrFire  = reset_n && wr_valid && wr_ready;
        rdFire  = reset_n && rd_valid && rd_ready;
        wData   = wr_data;
        if (!inReset) begin
            checkOutput("wr_ready_vs_occ", 32'(wr_ready), 32'(model.size() < DEPTH));
            if (rd_valid) checkOutput("rd_valid_nonempty", 32'(model.size() > 0), 32'd1);
        end
        if (rdFire) begin
            if (model.size() == 0) begin
                checkOutput("pop_underflow", 32'd0, 32'd1);
            end else begin
                expData = model.pop_front();
                checkOutput("rd_data", 32'(rd_data), 32'(expData));
                lastPop = rd_data;
                pops++;
            end
        end
        if (wrFire) model.push_back(wData);
        if (inReset) model.delete();
        @(posedge clk);
        #1;
        if (inReset) begin
            checkOutput("rst_csb1", 32'(sram_csb1), 32'd1);
            checkOutput("rst_web1", 32'(sram_web1), 32'd1);
            checkOutput("rst_csb2", 32'(sram_csb2), 32'd1);
            checkOutput("rst_oeb2", 32'(sram_oeb2), 32'd1);
            checkOutput("rst_a1", 32'(sram_a1), 32'd0);
            checkOutput("rst_a2", 32'(sram_a2), 32'd0);
            checkOutput("rst_i1", 32'(sram_i1), 32'd0);
            checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
`ifdef SRAM_FIFO_LEVEL_EN
            checkOutput("rst_level", 32'(level), 32'd0);
`endif
            expWrAddr   = '0;
            expRdAddr   = '0;
            prevA1Valid = 0;
            prevA2Valid = 0;
        end else begin
            checkOutput("csb1_cmd", 32'(sram_csb1), 32'(!wrFire));
            checkOutput("web1_cmd", 32'(sram_web1), 32'(!wrFire));
            if (wrFire) begin
                checkOutput("a1_seq", 32'(sram_a1), 32'(expWrAddr));
                checkOutput("i1_data", 32'(sram_i1), 32'(wData));
                if (prevA1Valid && prevA1 == 4'd15 && sram_a1 == 4'd0) sawWrWrap = 1;
                prevA1      = sram_a1;
                prevA1Valid = 1;
                expWrAddr++;
            end
            if (sram_csb2 == 1'b0) begin
                checkOutput("a2_seq", 32'(sram_a2), 32'(expRdAddr));
                checkOutput("oeb2_cmd", 32'(sram_oeb2), 32'd0);
                if (prevA2Valid && prevA2 == 4'd15 && sram_a2 == 4'd0) sawRdWrap = 1;
                prevA2      = sram_a2;
                prevA2Valid = 1;
                expRdAddr++;
            end else begin
                checkOutput("oeb2_idle", 32'(sram_oeb2), 32'd1);
            end
`ifdef SRAM_FIFO_LEVEL_EN
            checkOutput("level", 32'(level), 32'(model.size()));
`endif
        end
    endtask

    task automatic waitValid(input int maxCycles);
        for (int i = 0; i < maxCycles && !rd_valid; i++) applyStimulus();
        checkOutput("wait_rd_valid", 32'(rd_valid), 32'd1);
    endtask

    task automatic drain(input int maxCycles);
        rd_ready = 1'b1;
        for (int i = 0; i < maxCycles && model.size() > 0; i++) applyStimulus();
        checkOutput("drain_empty", 32'(model.size()), 32'd0);
        repeat (3) applyStimulus();
    endtask

    initial begin
        int            popsStart;
        int            nextIdx;
        bit            wrWill;
        logic [DW-1:0] held;

        reset_n  = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        rd_ready = 1'b0;
        repeat (3) applyStimulus();
        reset_n  = 1'b1;
        wr_valid = 1'b0;
        checkOutput("post_rst_wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("post_rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("oeb1_const", 32'(sram_oeb1), 32'd1);
        checkOutput("web2_const", 32'(sram_web2), 32'd1);
        applyStimulus();

        // Single word: rd_valid must rise exactly three edges after the accept edge.
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        rd_ready = 1'b1;
        applyStimulus();
        wr_valid = 1'b0;
        checkOutput("lat_e0", 32'(rd_valid), 32'd0);
        applyStimulus();
        checkOutput("lat_e1", 32'(rd_valid), 32'd0);
        applyStimulus();
        checkOutput("lat_e2", 32'(rd_valid), 32'd0);
        applyStimulus();
        checkOutput("lat_e3_valid", 32'(rd_valid), 32'd1);
        checkOutput("lat_e3_data", 32'(rd_data), 32'hA5);
        applyStimulus();
        checkOutput("single_pop_valid", 32'(rd_valid), 32'd0);
        repeat (2) applyStimulus();
        checkOutput("single_idle_csb2", 32'(sram_csb2), 32'd1);
        checkOutput("single_idle_valid", 32'(rd_valid), 32'd0);

        // Fill to full, then offer a 17th word that must not be written.
        rd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            applyStimulus();
        end
        checkOutput("full_wr_ready", 32'(wr_ready), 32'd0);
        wr_data = 8'hFF;
        applyStimulus();
        checkOutput("full_no_write", 32'(sram_csb1), 32'd1);
        applyStimulus();
        wr_valid = 1'b0;
        popsStart = pops;
        drain(200);
        checkOutput("fill_pop_count", 32'(pops - popsStart), 32'd16);

        // Randomised traffic of 40 words i*3, forcing both pointers around the ring.
        sawWrWrap = 0;
        sawRdWrap = 0;
        nextIdx   = 0;
        popsStart = pops;
        for (int cyc = 0; cyc < 3000 && (pops - popsStart) < 40; cyc++) begin
            wr_valid = (nextIdx < 40) && ($urandom_range(0, 1) == 1);
            wr_data  = 8'(nextIdx * 3);
            rd_ready = ($urandom_range(0, 1) == 1);
            wrWill   = wr_valid && wr_ready;
            applyStimulus();
            if (wrWill) nextIdx++;
        end
        wr_valid = 1'b0;
        checkOutput("wrap_pop_count", 32'(pops - popsStart), 32'd40);
        checkOutput("wrap_a1", 32'(sawWrWrap), 32'd1);
        checkOutput("wrap_a2", 32'(sawRdWrap), 32'd1);
        drain(50);

        // Backpressure in the hold state, with a further committed word waiting behind it.
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        applyStimulus();
        wr_valid = 1'b0;
        waitValid(10);
        held = rd_data;
        checkOutput("bp_head", 32'(held), 32'h5A);
        wr_valid = 1'b1;
        wr_data  = 8'hC3;
        applyStimulus();
        wr_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput("bp_valid", 32'(rd_valid), 32'd1);
            checkOutput("bp_data_stable", 32'(rd_data), 32'(held));
            checkOutput("bp_csb2", 32'(sram_csb2), 32'd1);
        end
        drain(50);

        // Reset with seven words queued and a read pending; afterwards only new data may appear.
        rd_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'($urandom);
            applyStimulus();
        end
        wr_valid = 1'b0;
        waitValid(10);
        checkOutput("mid_occ", 32'(model.size()), 32'd7);
        reset_n = 1'b0;
        applyStimulus();
        reset_n = 1'b1;
        checkOutput("mid_rst_valid", 32'(rd_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        applyStimulus();
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        lastPop  = 8'h00;
        popsStart = pops;
        for (int i = 0; i < 20 && pops == popsStart; i++) applyStimulus();
        checkOutput("mid_first_word", 32'(lastPop), 32'h3C);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
